pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Autonomous playback controller between memory_controller and cells_controller.
- On a trigger it reads a run of 16-bit cell-state frames from consecutive memory addresses.
- For each frame it presents the frame to the cell core, waits for update_done, then holds for a programmable dwell time.
- Supports single-shot and looped playback.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 16, frame (cell_state) width
TIMEOUT_CYCLES, 1024, maximum cycles allowed in WAIT_DONE before abort

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
enable_sn  in  1  synchronized enable, active-low; high forces IDLE
trigger_in_sn  in  1  synchronized trigger, active-low; a falling edge starts a run
base_address  in  ADDR_WIDTH  address of frame 0
frame_count  in  8  frames per run; 0 = no run
loop_mode  in  1  1 = restart at frame 0 after the last frame
dwell_cycles  in  32  hold time after each update_done
memory_enable_n  out  1  memory select, active-low
memory_read_n  out  1  memory read strobe, active-low
memory_address  out  ADDR_WIDTH  read address
memory_data_in  in  DATA_WIDTH  read data, valid one cycle after strobe
cell_state  out  DATA_WIDTH  current frame to cell core
system_enable_n  out  1  update request to cell core, active-low, one-cycle pulse
update_done  in  1  cell core completion, active-high
trigger_out_n  out  1  frame-start marker, active-low, one-cycle pulse
busy  out  1  run in progress
frame_index  out  8  index of the current frame
done  out  1  one-cycle pulse at the end of a single-shot run
error  out  1  sticky update_done timeout flag

Behaviour:
- Reset values:
  - memory_enable_n = memory_read_n = system_enable_n = trigger_out_n = 1.
  - memory_address, cell_state, frame_index, dwell and timeout counters = 0.
  - busy, done, error = 0.
  - State = IDLE; the trigger edge register = 1.
- Trigger detection:
  - A registered copy of trigger_in_sn is kept.
  - Start condition = previous 1 and current 0, in IDLE with enable_sn = 0 and frame_count != 0.
  - Edges seen in any other state are ignored.
- States:
  - IDLE: outputs inactive, busy 0. On start: frame_index <= 0, clear error, go READ.
  - READ (1 cycle):
    - memory_enable_n = memory_read_n = 0.
    - memory_address = base_address + frame_index, truncated mod 2^ADDR_WIDTH; wraps 0xFF -> 0x00.
    - Next state CAPTURE.
  - CAPTURE (1 cycle): cell_state <= memory_data_in, strobes high, go UPDATE.
  - UPDATE (1 cycle): system_enable_n = 0 and trigger_out_n = 0; timeout counter cleared; go WAIT_DONE.
  - WAIT_DONE:
    - If update_done = 1: load the dwell counter with dwell_cycles and go DWELL.
    - If update_done is already 1 in the first WAIT_DONE cycle, it is accepted.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 without update_done: error <= 1, go IDLE.
  - DWELL:
    - Counter decrements each cycle; at 0 go NEXT.
    - dwell_cycles = 0 means exactly 1 cycle in DWELL.
    - Total hold = max(dwell_cycles, 1) cycles.
  - NEXT (1 cycle):
    - If frame_index == frame_count-1: if loop_mode = 1, frame_index <= 0 and go READ; otherwise done pulse and go IDLE.
    - Otherwise frame_index <= frame_index+1 and go READ.
- Latency:
  - Trigger edge to READ: 1 cycle after the edge is registered.
  - READ to system_enable_n low: 2 cycles.
- busy = 1 in every state except IDLE.
- cell_state holds its last value in IDLE; it is not cleared at the end of a run.
- enable_sn going high in any state:
  - Next cycle is IDLE with all strobes inactive.
  - No done pulse; error unchanged.
  - frame_index retains its value.
- Inputs base_address, frame_count, loop_mode and dwell_cycles are sampled live. A change mid-run takes effect at the next use; firmware changes them only while busy = 0.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronously).

Test Plan:
- base=0x10, count=3, dwell=4, loop=0; memory holds 0xA5A5, 0x0F0F, 0x1234; update_done returned 2 cycles after each request -> three system_enable_n pulses with cell_state = those values in order, addresses 0x10/0x11/0x12, 4-cycle dwell gaps, one done pulse, then busy=0.
- base=0xFE, count=3, loop=1 -> addresses 0xFE, 0xFF, 0x00, 0xFE, ...; no done pulse; enable_sn high after the 5th update -> IDLE within 1 cycle, frame_index=1.
- update_done held 0 with TIMEOUT_CYCLES=16 -> error=1 after 16 WAIT_DONE cycles, busy=0; the next trigger clears error.
- frame_count=0 plus trigger -> stays IDLE, no memory strobes; a second trigger edge during a run -> no restart, frame sequence unchanged.
- dwell_cycles=0 and update_done already high -> system_enable_n pulses exactly 6 cycles apart.
- Reset pulsed mid-DWELL -> all outputs return to reset values asynchronously; after release, a new trigger runs from frame 0.

Source files
------------

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame playback controller: memory reads, cell-core updates, dwell, optional loop
module pattern_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_sn,
    input  logic                  trigger_in_sn,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [7:0]            frame_count,
    input  logic                  loop_mode,
    input  logic [31:0]           dwell_cycles,
    output logic                  memory_enable_n,
    output logic                  memory_read_n,
    output logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [DATA_WIDTH-1:0] memory_data_in,
    output logic [DATA_WIDTH-1:0] cell_state,
    output logic                  system_enable_n,
    input  logic                  update_done,
    output logic                  trigger_out_n,
    output logic                  busy,
    output logic [7:0]            frame_index,
    output logic                  done,
    output logic                  error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_UPDATE,
        S_WAIT_DONE,
        S_DWELL,
        S_NEXT
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic                    trig_q;
    logic                    start;
    logic                    last_frame;
    logic [7:0]              idx_n;
    logic                    done_n;
    logic                    error_n;
    logic [TW-1:0]           tmo_cnt;
    logic [31:0]             dwell_cnt;
    logic [ADDR_WIDTH-1:0]   next_addr;

    assign start      = (state == S_IDLE) && !enable_sn && (frame_count != 8'd0)
                        && trig_q && !trigger_in_sn;
    assign last_frame = (frame_index == 8'(frame_count - 8'd1));
    assign next_addr  = base_address + ADDR_WIDTH'(idx_n);

    always_comb begin
        state_n = state;
        idx_n   = frame_index;
        done_n  = 1'b0;
        error_n = error;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_READ;
                    idx_n   = 8'd0;
                    error_n = 1'b0;
                end
            end
            S_READ:    state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_UPDATE;
            S_UPDATE:  state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (update_done) begin
                    state_n = S_DWELL;
                end else if (tmo_cnt == TMO_MAX) begin
                    state_n = S_IDLE;
                    error_n = 1'b1;
                end
            end
            S_DWELL: begin
                if (dwell_cnt <= 32'd1) state_n = S_NEXT;
            end
            S_NEXT: begin
                if (last_frame) begin
                    if (loop_mode) begin
                        state_n = S_READ;
                        idx_n   = 8'd0;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n = S_READ;
                    idx_n   = frame_index + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Disable wins over everything and freezes index and error flag
        if (enable_sn) begin
            state_n = S_IDLE;
            idx_n   = frame_index;
            done_n  = 1'b0;
            error_n = error;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            trig_q         <= 1'b1;
            frame_index    <= 8'd0;
            memory_address <= '0;
            cell_state     <= '0;
            tmo_cnt        <= '0;
            dwell_cnt      <= 32'd0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state       <= state_n;
            trig_q      <= trigger_in_sn;
            frame_index <= idx_n;
            done        <= done_n;
            error       <= error_n;
            if (state_n == S_READ) memory_address <= next_addr;
            if (state == S_CAPTURE) cell_state <= memory_data_in;
            if (state == S_UPDATE) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == S_WAIT_DONE && update_done) begin
                dwell_cnt <= dwell_cycles;
            end else if (state == S_DWELL && dwell_cnt != 32'd0) begin
                dwell_cnt <= dwell_cnt - 32'd1;
            end
        end
    end

    assign memory_enable_n = (state != S_READ);
    assign memory_read_n   = (state != S_READ);
    assign system_enable_n = (state != S_UPDATE);
    assign trigger_out_n   = (state != S_UPDATE);
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_sn;
    logic        trigger_in_sn;
    logic [7:0]  base_address;
    logic [7:0]  frame_count;
    logic        loop_mode;
    logic [31:0] dwell_cycles;
    logic        memory_enable_n;
    logic        memory_read_n;
    logic [7:0]  memory_address;
    logic [15:0] memory_data_in;
    logic [15:0] cell_state;
    logic        system_enable_n;
    logic        update_done;
    logic        trigger_out_n;
    logic        busy;
    logic [7:0]  frame_index;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int since_req = 0;
    int done_mode = 0;
    int done_seen = 0;
    logic [15:0] mem [0:255];
    logic [7:0]  addr_q[$];
    logic [15:0] cs_q[$];
    int          upd_q[$];

    always #5 clock = ~clock;

    pattern_sequencer #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable_sn(enable_sn),
        .trigger_in_sn(trigger_in_sn),
        .base_address(base_address),
        .frame_count(frame_count),
        .loop_mode(loop_mode),
        .dwell_cycles(dwell_cycles),
        .memory_enable_n(memory_enable_n),
        .memory_read_n(memory_read_n),
        .memory_address(memory_address),
        .memory_data_in(memory_data_in),
        .cell_state(cell_state),
        .system_enable_n(system_enable_n),
        .update_done(update_done),
        .trigger_out_n(trigger_out_n),
        .busy(busy),
        .frame_index(frame_index),
        .done(done),
        .error(error)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock)
        if (!memory_enable_n && !memory_read_n) memory_data_in <= mem[memory_address];

    // done_mode: 0 = answer 2 cycles after request, 1 = held high, 2 = never
    always @(posedge clock)
        if (!system_enable_n) since_req <= 1;
        else if (since_req != 0) since_req <= since_req + 1;
    assign update_done = (done_mode == 1) || (done_mode == 0 && since_req == 2);

    always @(negedge clock) begin
        if (!reset) begin
            if (!memory_enable_n && !memory_read_n) addr_q.push_back(memory_address);
            if (!system_enable_n) begin
                cs_q.push_back(cell_state);
                upd_q.push_back(cyc);
            end
            if (done) done_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fire_trigger();
        trigger_in_sn = 1'b0;
        step();
        trigger_in_sn = 1'b1;
    endtask

    task automatic clear_log();
        addr_q.delete();
        cs_q.delete();
        upd_q.delete();
        done_seen = 0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            step();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int err_cyc;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A00;
        mem[8'h10] = 16'hA5A5;
        mem[8'h11] = 16'h0F0F;
        mem[8'h12] = 16'h1234;
        reset = 1'b1;
        enable_sn = 1'b1;
        trigger_in_sn = 1'b1;
        base_address = 8'h00;
        frame_count = 8'd0;
        loop_mode = 1'b0;
        dwell_cycles = 32'd0;
        done_mode = 0;

        #12;
        check("rst_strobes", 32'({memory_enable_n, memory_read_n, system_enable_n, trigger_out_n}), 32'hF);
        check("rst_flags", 32'({busy, done, error}), 32'h0);
        check("rst_cell_state", 32'(cell_state), 32'h0);
        check("rst_index_addr", 32'({frame_index, memory_address}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        enable_sn = 1'b0;
        step();

        // single-shot run of three frames
        base_address = 8'h10; frame_count = 8'd3; dwell_cycles = 32'd4; loop_mode = 1'b0;
        clear_log();
        fire_trigger();
        check("t1_read_strobe", 32'({memory_enable_n, memory_read_n}), 32'h0);
        check("t1_first_addr", 32'(memory_address), 32'h10);
        wait_idle("t1_idle", 100);
        step();
        check("t1_nupd", 32'(cs_q.size()), 32'd3);
        check("t1_cs0", 32'(cs_q[0]), 32'hA5A5);
        check("t1_cs1", 32'(cs_q[1]), 32'h0F0F);
        check("t1_cs2", 32'(cs_q[2]), 32'h1234);
        check("t1_addr0", 32'(addr_q[0]), 32'h10);
        check("t1_addr1", 32'(addr_q[1]), 32'h11);
        check("t1_addr2", 32'(addr_q[2]), 32'h12);
        check("t1_gap01", 32'(upd_q[1] - upd_q[0]), 32'd10);
        check("t1_gap12", 32'(upd_q[2] - upd_q[1]), 32'd10);
        check("t1_done_cnt", 32'(done_seen), 32'd1);
        check("t1_done_low", 32'(done), 32'd0);
        check("t1_hold_cs", 32'(cell_state), 32'h1234);
        check("t1_index", 32'(frame_index), 32'd2);

        // looped run with address wrap, stopped by enable
        base_address = 8'hFE; frame_count = 8'd3; dwell_cycles = 32'd1; loop_mode = 1'b1;
        clear_log();
        fire_trigger();
        n = 0;
        for (int k = 0; k < 200 && n < 5; k++) begin
            step();
            if (!system_enable_n) n++;
        end
        check("t2_nupd", 32'(n), 32'd5);
        enable_sn = 1'b1;
        step();
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_strobes", 32'({memory_enable_n, memory_read_n, system_enable_n, trigger_out_n}), 32'hF);
        check("t2_index", 32'(frame_index), 32'd1);
        step_n(3);
        check("t2_no_done", 32'(done_seen), 32'd0);
        check("t2_naddr", 32'(addr_q.size()), 32'd5);
        check("t2_addr2", 32'(addr_q[2]), 32'h00);
        check("t2_addr3", 32'(addr_q[3]), 32'hFE);
        check("t2_addr4", 32'(addr_q[4]), 32'hFF);
        enable_sn = 1'b0;
        loop_mode = 1'b0;
        step();

        // update_done timeout
        done_mode = 2;
        base_address = 8'h10; frame_count = 8'd1; dwell_cycles = 32'd0;
        clear_log();
        fire_trigger();
        err_cyc = -1;
        for (int k = 0; k < 100 && err_cyc < 0; k++) begin
            step();
            if (error) err_cyc = cyc;
        end
        check("t3_error", 32'(error), 32'd1);
        check("t3_err_latency", 32'(err_cyc - upd_q[0]), 32'd17);
        check("t3_busy", 32'(busy), 32'd0);
        done_mode = 0;
        fire_trigger();
        check("t3_err_clear", 32'({busy, error}), 32'h2);
        wait_idle("t3_idle", 100);
        step();

        // zero frame_count, then a retrigger mid-run
        frame_count = 8'd0;
        clear_log();
        fire_trigger();
        step_n(4);
        check("t4_no_run", 32'(busy), 32'd0);
        check("t4_no_strobe", 32'(addr_q.size()), 32'd0);
        frame_count = 8'd2; dwell_cycles = 32'd2;
        clear_log();
        fire_trigger();
        step_n(3);
        trigger_in_sn = 1'b0;
        step();
        trigger_in_sn = 1'b1;
        wait_idle("t4_idle", 100);
        step();
        check("t4_naddr", 32'(addr_q.size()), 32'd2);
        check("t4_addr1", 32'(addr_q[1]), 32'h11);
        check("t4_nupd", 32'(cs_q.size()), 32'd2);
        check("t4_done_cnt", 32'(done_seen), 32'd1);

        // zero dwell with update_done already high
        done_mode = 1;
        base_address = 8'h20; frame_count = 8'd3; dwell_cycles = 32'd0;
        clear_log();
        fire_trigger();
        wait_idle("t5_idle", 100);
        step();
        check("t5_nupd", 32'(upd_q.size()), 32'd3);
        check("t5_gap01", 32'(upd_q[1] - upd_q[0]), 32'd6);
        check("t5_gap12", 32'(upd_q[2] - upd_q[1]), 32'd6);
        check("t5_done_cnt", 32'(done_seen), 32'd1);

        // asynchronous reset in DWELL
        done_mode = 0;
        base_address = 8'h10; frame_count = 8'd2; dwell_cycles = 32'd20;
        clear_log();
        fire_trigger();
        step_n(6);
        check("t6_busy_dwell", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_strobes", 32'({memory_enable_n, memory_read_n, system_enable_n, trigger_out_n}), 32'hF);
        check("t6_flags", 32'({busy, done, error}), 32'h0);
        check("t6_cell_state", 32'(cell_state), 32'h0);
        check("t6_index_addr", 32'({frame_index, memory_address}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step();
        clear_log();
        fire_trigger();
        check("t6_restart", 32'({busy, frame_index, memory_address}), 32'h10010);
        wait_idle("t6_idle", 200);
        step();
        check("t6_cs0", 32'(cs_q[0]), 32'hA5A5);
        check("t6_done_cnt", 32'(done_seen), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
